// File: rtl/minitb_ahb_slave_mem.sv
// AHB-lite subset slave memory with IDLE/NONSEQ decode, word storage,
// configurable hready wait states and completed-transfer counters.
//
// Ports:
//   hclk, hreset           clock, async active-high reset
//   htrans, haddr, hwrite  address phase (sampled when hready=1)
//   hwdata                 write data, taken at the final data-phase edge
//   hrdata, hready         read data / data-phase completion
//   wr_count, rd_count     wrapping counts of completed writes / reads
module minitb_ahb_slave_mem #(
  parameter int addrWidth   = 8,
  parameter int dataWidth   = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                 hclk,
  input  logic                 hreset,
  input  logic [1:0]           htrans,
  input  logic [addrWidth-1:0] haddr,
  input  logic                 hwrite,
  input  logic [dataWidth-1:0] hwdata,
  output logic [dataWidth-1:0] hrdata,
  output logic                 hready,
  output logic [15:0]          wr_count,
  output logic [15:0]          rd_count
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [addrWidth:0] DEPTH_W =
    (addrWidth+1)'(DEPTH);
  localparam logic [3:0] WS_W = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DATA
  } state_e;

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [addrWidth-1:0] addr_q, addr_d;
  logic                 write_q, write_d;
  logic [15:0]          wr_cnt_q, wr_cnt_d;
  logic [15:0]          rd_cnt_q, rd_cnt_d;
  logic [dataWidth-1:0] mem_q [DEPTH];

  logic          sample;
  logic          in_range;
  logic          commit;
  logic [IW-1:0] idx;

  assign hready   = (state_q != S_WAIT);
  assign sample   = hready && (htrans == 2'b10);
  assign in_range = ({1'b0, addr_q} < DEPTH_W);
  assign idx      = IW'(addr_q);
  assign commit   = (state_q == S_DATA) && write_q
                    && in_range;

  assign wr_count = wr_cnt_q;
  assign rd_count = rd_cnt_q;

  // Reads are served straight from the array, so a write
  // committing on the edge that samples a read is visible.
  assign hrdata = ((state_q == S_DATA) && !write_q
                   && in_range) ? mem_q[idx] : '0;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    write_d  = write_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    if (sample) begin
      addr_d  = haddr;
      write_d = hwrite;
    end
    unique case (state_q)
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_DATA;
      end
      default: begin
        // IDLE and DATA both accept a new address;
        // DATA also retires the pending transfer.
        if (state_q == S_DATA) begin
          if (write_q) wr_cnt_d = wr_cnt_q + 16'd1;
          else         rd_cnt_d = rd_cnt_q + 16'd1;
        end
        if (sample) begin
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = WS_W;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (commit) begin
      mem_q[idx] <= hwdata;
    end
  end

endmodule

// File: tb/tb_minitb_ahb_slave_mem.sv
// Bench for minitb_ahb_slave_mem: three instances (0, 3 and 2 wait
// states, the last with 16 words) driven by a small pipelined master.
module tb_minitb_ahb_slave_mem;

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] data;
  } op_t;

  logic        hclk;
  logic        hreset [3];
  logic [1:0]  htrans [3];
  logic [7:0]  haddr  [3];
  logic        hwrite [3];
  logic [31:0] hwdata [3];
  logic [31:0] hrdata [3];
  logic        hready [3];
  logic [15:0] wr_cnt [3];
  logic [15:0] rd_cnt [3];

  int          depth_k [3] = '{256, 256, 16};
  int          ws_k    [3] = '{0, 3, 2};
  logic [31:0] mdl [3][256];
  int          exp_wr [3];
  int          exp_rd [3];
  op_t         ops [$];
  logic [31:0] sb  [$];
  int          vectors = 0;
  int          miscompares = 0;
  int          last_cycles;
  int          last_waits;

  minitb_ahb_slave_mem #(
    .WAIT_STATES(0)
  ) u0 (
    .hclk(hclk), .hreset(hreset[0]),
    .htrans(htrans[0]), .haddr(haddr[0]),
    .hwrite(hwrite[0]), .hwdata(hwdata[0]),
    .hrdata(hrdata[0]), .hready(hready[0]),
    .wr_count(wr_cnt[0]), .rd_count(rd_cnt[0])
  );

  minitb_ahb_slave_mem #(
    .WAIT_STATES(3)
  ) u1 (
    .hclk(hclk), .hreset(hreset[1]),
    .htrans(htrans[1]), .haddr(haddr[1]),
    .hwrite(hwrite[1]), .hwdata(hwdata[1]),
    .hrdata(hrdata[1]), .hready(hready[1]),
    .wr_count(wr_cnt[1]), .rd_count(rd_cnt[1])
  );

  minitb_ahb_slave_mem #(
    .DEPTH(16),
    .WAIT_STATES(2)
  ) u2 (
    .hclk(hclk), .hreset(hreset[2]),
    .htrans(htrans[2]), .haddr(haddr[2]),
    .hwrite(hwrite[2]), .hwdata(hwdata[2]),
    .hrdata(hrdata[2]), .hready(hready[2]),
    .wr_count(wr_cnt[2]), .rd_count(rd_cnt[2])
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic check(string tag, logic [31:0] obs,
                       logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic push_op(bit wr, logic [7:0] a,
                         logic [31:0] d);
    op_t o;
    o.wr = wr; o.addr = a; o.data = d;
    ops.push_back(o);
  endtask

  task automatic check_counts(int k, string tag);
    check({tag, "_wr"}, {16'h0, wr_cnt[k]}, exp_wr[k]);
    check({tag, "_rd"}, {16'h0, rd_cnt[k]}, exp_rd[k]);
  endtask

  // Issues the queued ops back to back; expected read data is
  // pushed to the scoreboard when each address is accepted.
  task automatic run(int k);
    op_t dp;
    bit  have = 0;
    bit  rdy;
    int  guard = 0;
    last_cycles = 0;
    last_waits  = 0;
    while ((ops.size() > 0 || have) && guard < 200) begin
      guard++;
      if (ops.size() > 0) begin
        htrans[k] = 2'b10;
        haddr[k]  = ops[0].addr;
        hwrite[k] = ops[0].wr;
      end else begin
        htrans[k] = 2'b00;
        haddr[k]  = 8'h00;
        hwrite[k] = 1'b0;
      end
      if (have) hwdata[k] = hready[k] ? dp.data : ~dp.data;
      else      hwdata[k] = 32'h0;
      @(negedge hclk);
      rdy = hready[k];
      if (have && !rdy) last_waits++;
      if (have && rdy) begin
        if (dp.wr) exp_wr[k]++;
        else begin
          exp_rd[k]++;
          check("rdata", hrdata[k], sb.pop_front());
        end
        have = 0;
      end
      if (rdy && ops.size() > 0) begin
        dp   = ops.pop_front();
        have = 1;
        if (dp.wr) begin
          if (int'(dp.addr) < depth_k[k])
            mdl[k][dp.addr] = dp.data;
        end else begin
          sb.push_back((int'(dp.addr) < depth_k[k])
                       ? mdl[k][dp.addr] : 32'h0);
        end
      end
      last_cycles++;
      @(posedge hclk);
      #1;
    end
    check("no_timeout", {31'h0, guard < 200}, 32'h1);
    htrans[k] = 2'b00;
    hwdata[k] = 32'h0;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      hreset[k] = 1'b1;
      htrans[k] = 2'b00;
      haddr[k]  = 8'h00;
      hwrite[k] = 1'b0;
      hwdata[k] = 32'h0;
      exp_wr[k] = 0;
      exp_rd[k] = 0;
      for (int a = 0; a < 256; a++) mdl[k][a] = 32'h0;
    end
    repeat (2) @(posedge hclk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check("rst_hready", {31'h0, hready[k]}, 32'h1);
      check("rst_hrdata", hrdata[k], 32'h0);
      check_counts(k, "rst");
      hreset[k] = 1'b0;
    end

    // idle after reset
    for (int c = 0; c < 5; c++) begin
      @(negedge hclk);
      for (int k = 0; k < 3; k++) begin
        check("idle_hready", {31'h0, hready[k]}, 32'h1);
        check("idle_hrdata", hrdata[k], 32'h0);
        check_counts(k, "idle");
      end
    end
    @(posedge hclk);
    #1;
    push_op(0, 8'h00, 32'h0);
    run(0);
    check_counts(0, "rd0");

    // single write/read, no wait states
    push_op(1, 8'h10, 32'hDEADBEEF);
    run(0);
    push_op(0, 8'h10, 32'h0);
    run(0);
    check("single_lat", last_cycles, 32'd2);
    check_counts(0, "single");

    // three wait states, junk hwdata during waits
    push_op(1, 8'h05, 32'h12345678);
    run(1);
    check("ws3_waits", last_waits, 32'd3);
    check("ws3_cycles", last_cycles, 32'd5);
    push_op(0, 8'h05, 32'h0);
    run(1);
    check("ws3_rd_waits", last_waits, 32'd3);
    check_counts(1, "ws3");

    // back-to-back write then read of the same word
    push_op(1, 8'h20, 32'hA5A5A5A5);
    push_op(0, 8'h20, 32'h0);
    push_op(0, 8'h10, 32'h0);
    run(0);
    check("b2b_cycles", last_cycles, 32'd4);
    check_counts(0, "b2b");

    // reset during the first wait cycle
    htrans[2] = 2'b10;
    haddr[2]  = 8'h30;
    hwrite[2] = 1'b1;
    @(posedge hclk);
    #1;
    htrans[2] = 2'b00;
    hwdata[2] = 32'h1;
    check("mid_wait", {31'h0, hready[2]}, 32'h0);
    hreset[2] = 1'b1;
    #1;
    check("mid_hready", {31'h0, hready[2]}, 32'h1);
    check("mid_wr", {16'h0, wr_cnt[2]}, 32'h0);
    @(posedge hclk);
    #1;
    hreset[2] = 1'b0;
    hwdata[2] = 32'h0;
    push_op(0, 8'h30, 32'h0);
    run(2);
    check_counts(2, "mid");

    // out-of-range on the 16-word instance
    push_op(1, 8'h00, 32'hCAFE0001);
    push_op(1, 8'h0F, 32'h0F0F0F0F);
    push_op(1, 8'h40, 32'hFFFF0000);
    push_op(0, 8'h40, 32'h0);
    push_op(0, 8'h00, 32'h0);
    push_op(0, 8'h0F, 32'h0);
    push_op(0, 8'h10, 32'h0);
    run(2);
    check("oor_cycles", last_cycles, 32'd22);
    check("oor_waits", last_waits, 32'd14);
    check_counts(2, "oor");

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
